// File: rtl/wbm_bytes_pkg.sv
// wbm_bytes_pkg: shared state encoding, status reply codes and command bit positions for wbm_bytes.
package wbm_bytes_pkg;
    typedef enum logic [2:0] {IDLE, COUNT, ADDR, WDATA, WAIT, RDATA} WbmBytesState;
    localparam logic [7:0] STATUS_BUSY = 8'h00;
    localparam logic [7:0] STATUS_DONE = 8'h01;
    localparam logic [7:0] STATUS_ERR  = 8'h03;
    localparam int CMD_W_BIT = 7;
    localparam int CMD_I_BIT = 6;
endpackage

// File: rtl/wbm_bytes_watchdog.sv
// wbm_bytes_watchdog: counts clocks while a bus cycle is open and flags when TIMEOUT is reached.
// Ports: wb_clk_i/wb_rst_ni clock and async active-low reset; cyc bus cycle open;
// clear restart the count; expired one-cycle pulse on the TIMEOUT-th open cycle.
module wbm_bytes_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic wb_clk_i,
    input  logic wb_rst_ni,
    input  logic cyc,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) r_cnt <= '0;
        else            r_cnt <= (cyc && !clear) ? r_cnt + 1'b1 : '0;
    end
    // The owner drops cyc on this pulse, so the count restarts by itself.
    assign expired = cyc && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/wbm_bytes.sv
// wbm_bytes: Wishbone B4 pipelined master driven by a local host byte stream, with bursts.
// Optional: define WBM_BYTES_TIMEOUT_EN to abort bus cycles that stay open for TIMEOUT clocks.
// Ports: wb_clk_i/wb_rst_ni clock and async active-low reset; rx_stb/rx_data host byte in;
// tx_stb/tx_data reply byte out (one per host byte); wb_* Wishbone pipelined master port.
module wbm_bytes
    import wbm_bytes_pkg::*;
#(
    parameter int ADR_BYTES = 1,
    parameter int DAT_BYTES = 4,
    parameter int TIMEOUT   = 1023,
    localparam int LB = $clog2(DAT_BYTES),
    localparam int AW = 8 * ADR_BYTES + LB,
    localparam int DW = 8 * DAT_BYTES
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 rx_stb,
    input  logic [7:0]           rx_data,
    output logic                 tx_stb,
    output logic [7:0]           tx_data,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [DAT_BYTES-1:0] wb_sel_o,
    output logic [AW-1:0]        wb_adr_o,
    output logic [DW-1:0]        wb_dat_o,
    input  logic [DW-1:0]        wb_dat_i,
    input  logic                 wb_stall_i,
    input  logic                 wb_ack_i
);
    localparam int WW = 8 * ADR_BYTES;
    if (ADR_BYTES < 1 || ADR_BYTES > 3 || (DAT_BYTES != 1 && DAT_BYTES != 2 && DAT_BYTES != 4) || TIMEOUT < 1) begin : g_bad_param
        $error("wbm_bytes: unsupported parameter set");
    end
    WbmBytesState  r_state;
    logic          r_inc;
    logic          r_done;
    logic [8:0]    r_cnt;
    logic [1:0]    r_bcnt;
    logic [WW-1:0] r_wadr;
    logic [DW-1:0] r_rdat;
`ifdef WBM_BYTES_TIMEOUT_EN
    logic w_expired;
    logic r_err;
    wbm_bytes_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .wb_clk_i(wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .cyc(wb_cyc_o),
        .clear(wb_ack_i),
        .expired(w_expired)
    );
`endif
    // Word address is kept separately so the byte-lane bits stay zero and wrap is natural.
    assign wb_adr_o = AW'(r_wadr) << LB;
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state  <= IDLE;
            r_inc    <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_bcnt   <= '0;
            r_wadr   <= '0;
            r_rdat   <= '0;
            tx_stb   <= 1'b0;
            tx_data  <= '0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
`ifdef WBM_BYTES_TIMEOUT_EN
            r_err    <= 1'b0;
`endif
        end else begin
            tx_stb <= rx_stb;
            if (wb_cyc_o) begin
                if (!wb_stall_i) wb_stb_o <= 1'b0;
                if (wb_ack_i) begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    r_done   <= 1'b1;
                    r_rdat   <= wb_dat_i;
                    if (r_inc) r_wadr <= r_wadr + 1'b1;
                end
`ifdef WBM_BYTES_TIMEOUT_EN
                else if (w_expired) begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    r_err    <= 1'b1;
                end
`endif
            end
            if (rx_stb) begin
                tx_data <= STATUS_BUSY;
                case (r_state)
                    IDLE: if (rx_data != 8'h00) begin
                        wb_we_o  <= rx_data[CMD_W_BIT];
                        r_inc    <= rx_data[CMD_I_BIT];
                        wb_sel_o <= rx_data[DAT_BYTES-1:0];
                        r_state  <= COUNT;
                    end
                    COUNT: begin
                        r_cnt   <= {1'b0, rx_data} + 9'd1;
                        r_bcnt  <= '0;
                        r_state <= ADDR;
                    end
                    ADDR: begin
                        r_wadr <= (r_wadr << 8) | WW'(rx_data);
                        r_bcnt <= r_bcnt + 1'b1;
                        if (r_bcnt == 2'(ADR_BYTES - 1)) begin
                            r_bcnt  <= '0;
                            r_state <= wb_we_o ? WDATA : WAIT;
                            wb_cyc_o <= !wb_we_o;
                            wb_stb_o <= !wb_we_o;
                        end
                    end
                    WDATA: begin
                        wb_dat_o <= (wb_dat_o << 8) | DW'(rx_data);
                        r_bcnt   <= r_bcnt + 1'b1;
                        if (r_bcnt == 2'(DAT_BYTES - 1)) begin
                            r_bcnt   <= '0;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            r_state  <= WAIT;
                        end
                    end
                    WAIT:
`ifdef WBM_BYTES_TIMEOUT_EN
                    if (r_err) begin
                        tx_data <= STATUS_ERR;
                        r_err   <= 1'b0;
                        r_done  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else
`endif
                    if (r_done) begin
                        tx_data <= STATUS_DONE;
                        r_done  <= 1'b0;
                        r_cnt   <= (r_cnt != 9'd0) ? r_cnt - 9'd1 : r_cnt;
                        r_state <= !wb_we_o ? RDATA : (r_cnt > 9'd1) ? WDATA : IDLE;
                    end
                    RDATA: begin
                        tx_data <= r_rdat[DW-1 -: 8];
                        r_rdat  <= r_rdat << 8;
                        r_bcnt  <= r_bcnt + 1'b1;
                        if (r_bcnt == 2'(DAT_BYTES - 1)) begin
                            r_bcnt   <= '0;
                            wb_cyc_o <= r_cnt != 9'd0;
                            wb_stb_o <= r_cnt != 9'd0;
                            r_state  <= (r_cnt != 9'd0) ? WAIT : IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wbm_bytes.sv
// tb_wbm_bytes: randomized host/slave transaction model checking every reply byte and bus transfer of wbm_bytes.
`timescale 1ns/1ps
module tb_wbm_bytes;
    localparam int AB = 1;
    localparam int DB = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_stb = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic tx_stb;
    logic [7:0] tx_data;
    logic wb_cyc_o, wb_stb_o, wb_we_o;
    logic [DB-1:0] wb_sel_o;
    logic [9:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic wb_stall_i = 1'b0;
    logic wb_ack_i = 1'b0;
    int n_tests = 0, n_fail = 0, cyc_n = 0, rx_edge = 0, ack_edge = 0, gap_max = 2;
    int sl_stall = 0, sl_wait = 0, st_left = 0, wt_left = 0;
    bit sl_noack = 0, sl_spur = 0, sl_use_fix = 0, acc = 0;
    logic [31:0] sl_fix = '0;
    logic rx_q = 1'b0;
    typedef struct { logic [9:0] adr; logic we; logic [3:0] sel; logic [31:0] dout; logic [31:0] din; } xfer_t;
    xfer_t q_log[$];

    wbm_bytes #(.ADR_BYTES(AB), .DAT_BYTES(DB), .TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .rx_stb(rx_stb), .rx_data(rx_data),
        .tx_stb(tx_stb), .tx_data(tx_data), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        rx_q  <= rx_stb;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every host byte must be answered exactly one clock later, and never otherwise.
    always @(negedge clk) if (rst_n) chk("tx_stb", 32'(tx_stb), 32'(rx_q));

    // Behavioural pipelined slave: stalls sl_stall cycles, acks sl_wait cycles after acceptance.
    always @(negedge clk) begin
        wb_ack_i = 1'b0;
        if (sl_spur) begin
            wb_ack_i = 1'b1;
            wb_dat_i = $urandom;
            sl_spur = 0;
        end else if (!wb_cyc_o) begin
            acc = 0;
            st_left = sl_stall;
            wb_stall_i = 1'b0;
        end else begin
            if (!acc && wb_stb_o) begin
                if (st_left > 0) begin
                    wb_stall_i = 1'b1;
                    st_left--;
                end else begin
                    wb_stall_i = 1'b0;
                    acc = 1;
                    wt_left = sl_wait;
                    wb_dat_i = sl_use_fix ? sl_fix : $urandom;
                    q_log.push_back('{wb_adr_o, wb_we_o, wb_sel_o, wb_dat_o, wb_dat_i});
                end
            end
            if (acc && !sl_noack) begin
                if (wt_left == 0) begin
                    wb_ack_i = 1'b1;
                    ack_edge = cyc_n + 1;
                end else wt_left--;
            end
        end
    end

    task automatic send(input logic [7:0] b, output logic [7:0] r);
        @(negedge clk);
        rx_stb = 1'b1;
        rx_data = b;
        rx_edge = cyc_n + 1;
        @(negedge clk);
        rx_stb = 1'b0;
        r = tx_data;
        repeat ($urandom_range(gap_max)) @(negedge clk);
    endtask

    // A poll reports done only if the ack landed on an earlier clock than the poll itself.
    task automatic poll(input string tag);
        logic [7:0] r, e;
        for (int i = 0; i < 64; i++) begin
            send(8'($urandom), r);
            e = (ack_edge != 0 && ack_edge < rx_edge) ? 8'h01 : 8'h00;
            chk(tag, r, e);
            if (e == 8'h01) begin
                ack_edge = 0;
                return;
            end
        end
        chk({tag, "_bound"}, 0, 1);
    endtask

    task automatic frame(input bit w, input bit inc, input logic [3:0] s, input logic [7:0] n, input logic [7:0] a, input logic [31:0] wfix);
        logic [7:0] r;
        logic [31:0] wd;
        xfer_t x;
        send({w, inc, 2'b00, s}, r); chk("cmd_reply", r, 0);
        send(n, r); chk("cnt_reply", r, 0);
        send(a, r); chk("adr_reply", r, 0);
        for (int t = 0; t <= int'(n); t++) begin
            wd = (t == 0 && wfix != 0) ? wfix : $urandom;
            if (w) for (int k = DB - 1; k >= 0; k--) begin
                send(wd[8*k +: 8], r);
                chk("wdat_reply", r, 0);
            end
            poll("poll");
            if (q_log.size() == 0) chk("xfer_seen", 0, 1);
            else begin
                x = q_log.pop_front();
                chk("adr_o", 32'(x.adr), 32'(((int'(a) + (inc ? t : 0)) % 256) * 4));
                chk("we_o", 32'(x.we), 32'(w));
                chk("sel_o", 32'(x.sel), 32'(s));
                if (w) chk("dat_o", x.dout, wd);
                else for (int k = DB - 1; k >= 0; k--) begin
                    send(8'($urandom), r);
                    chk("rdat_reply", r, 32'(x.din[8*k +: 8]));
                end
            end
        end
        chk("cyc_idle", 32'(wb_cyc_o), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tx_stb"}, 32'(tx_stb), 0);
        chk({tag, "_tx_data"}, 32'(tx_data), 0);
        chk({tag, "_cyc"}, 32'(wb_cyc_o), 0);
        chk({tag, "_stb"}, 32'(wb_stb_o), 0);
        chk({tag, "_we"}, 32'(wb_we_o), 0);
        chk({tag, "_sel"}, 32'(wb_sel_o), 0);
        chk({tag, "_adr"}, 32'(wb_adr_o), 0);
        chk({tag, "_dat"}, wb_dat_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;
        int n;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        sl_use_fix = 1; sl_fix = 32'hDEADBEEF;
        frame(0, 0, 4'hF, 8'h00, 8'h12, 0);
        sl_use_fix = 0;
        sl_stall = 2;
        frame(1, 0, 4'hF, 8'h00, 8'h05, 32'h11223344);
        sl_stall = $urandom_range(3);
        frame(1, 1, 4'hF, 8'h02, 8'hFF, 0);
        gap_max = 0; sl_stall = 0; sl_wait = 1;
        frame(0, 1, 4'h3, 8'h01, 8'h40, 0);
        frame(1, 0, 4'hC, 8'h01, 8'h41, 0);
        sl_spur = 1;
        repeat (2) @(negedge clk);
        sl_stall = 3; sl_wait = 2;
        frame(0, 0, 4'h5, 8'h00, 8'h22, 0);
        for (int i = 0; i < 10; i++) begin
            gap_max = $urandom_range(3);
            sl_stall = $urandom_range(3);
            sl_wait = $urandom_range(3);
            frame(1'($urandom), 1'($urandom), 4'($urandom_range(15, 1)), 8'($urandom_range(4)), 8'($urandom), 0);
        end
        gap_max = 0; sl_stall = 0; sl_wait = 0;
        frame(0, 1, 4'hF, 8'hFF, 8'($urandom), 0);
        sl_noack = 1;
        send(8'h0F, r); send(8'h00, r); send(8'h30, r);
        @(negedge clk);
        chk("pre_rst_cyc", 32'(wb_cyc_o), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        sl_noack = 0; q_log.delete(); ack_edge = 0;
        send(8'h00, r); chk("post_rst_zero", r, 0);
        chk("post_rst_cyc", 32'(wb_cyc_o), 0);
        frame(0, 0, 4'hF, 8'h00, 8'h31, 0);
`ifdef WBM_BYTES_TIMEOUT_EN
        sl_noack = 1;
        send(8'h0F, r); send(8'h00, r); send(8'h20, r);
        n = 0;
        while (wb_cyc_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("wd_cycles", n, 16);
        send(8'h55, r); chk("wd_status", r, 8'h03);
        sl_noack = 0; q_log.delete();
        send(8'h00, r); chk("wd_idle", r, 0);
        frame(1, 0, 4'hF, 8'h00, 8'h21, 0);
`endif
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
